// File: rtl/crc_frame_serializer_if.sv
// rtl/crc_frame_serializer_if.sv - byte load handshake and serial CRC drive signals
interface crc_frame_serializer_if;
    logic [7:0] In_Data;
    logic       In_Valid;
    logic       In_Ready;
    logic       Flush;
    logic       Ser_Data;
    logic       Active;
    logic       Busy;
    logic       Frame_Done;

    modport master (
        output In_Data, In_Valid, Flush,
        input  In_Ready, Ser_Data, Active, Busy, Frame_Done
    );

    modport slave (
        input  In_Data, In_Valid, Flush,
        output In_Ready, Ser_Data, Active, Busy, Frame_Done
    );
endinterface

// File: rtl/crc_frame_serializer.sv
// rtl/crc_frame_serializer.sv - collects a byte frame and bursts it LSB-first into a serial CRC-8 engine
module crc_frame_serializer #(
    parameter int DATA_LENGTH  = 1,
    parameter int DRAIN_CYCLES = 9
) (
    input logic                    CLK,
    input logic                    RST,
    crc_frame_serializer_if.slave  bus
);
    localparam int NBITS   = DATA_LENGTH * 8;
    localparam int BYTE_W  = $clog2(DATA_LENGTH + 1);
    localparam int BIT_W   = $clog2(NBITS);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [BYTE_W-1:0]  byte_cnt, byte_cnt_n;
    logic [BIT_W-1:0]   bit_cnt, bit_cnt_n;
    logic [DRAIN_W-1:0] drain_cnt, drain_cnt_n;
    logic [NBITS-1:0]   buffer;
    logic               wr_en;
    logic               last_drain;

    assign last_drain = (state == DRAIN) && (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= LOAD;
            byte_cnt  <= '0;
            bit_cnt   <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_n;
            byte_cnt  <= byte_cnt_n;
            bit_cnt   <= bit_cnt_n;
            drain_cnt <= drain_cnt_n;
        end
    end

    // Buffer is never cleared; only slots written this frame reach the shifter.
    always_ff @(posedge CLK) begin
        for (int b = 0; b < DATA_LENGTH; b++) begin
            if (wr_en && (byte_cnt == BYTE_W'(b)))
                buffer[b*8 +: 8] <= bus.In_Data;
        end
    end

    always_comb begin
        state_n     = state;
        byte_cnt_n  = byte_cnt;
        bit_cnt_n   = bit_cnt;
        drain_cnt_n = drain_cnt;
        wr_en       = 1'b0;
        case (state)
            LOAD: begin
                if (bus.Flush) begin
                    byte_cnt_n = '0;
                end else if (bus.In_Valid) begin
                    wr_en      = 1'b1;
                    byte_cnt_n = byte_cnt + BYTE_W'(1);
                    if (byte_cnt == BYTE_W'(DATA_LENGTH - 1)) begin
                        state_n   = SHIFT;
                        bit_cnt_n = '0;
                    end
                end
            end
            SHIFT: begin
                // A flush still routes through DRAIN so the engine re-initialises.
                if (bus.Flush || (bit_cnt == BIT_W'(NBITS - 1))) begin
                    state_n     = DRAIN;
                    drain_cnt_n = '0;
                end else begin
                    bit_cnt_n = bit_cnt + BIT_W'(1);
                end
            end
            DRAIN: begin
                if (last_drain) begin
                    state_n    = LOAD;
                    byte_cnt_n = '0;
                end else begin
                    drain_cnt_n = drain_cnt + DRAIN_W'(1);
                end
            end
            default: begin
                state_n = LOAD;
            end
        endcase
    end

    assign bus.In_Ready   = (state == LOAD);
    assign bus.Active     = (state == SHIFT);
    assign bus.Ser_Data   = (state == SHIFT) && buffer[bit_cnt];
    assign bus.Busy       = (state == SHIFT) || (state == DRAIN);
    assign bus.Frame_Done = last_drain;
endmodule

// File: tb/tb_crc_frame_serializer.sv
// tb/tb_crc_frame_serializer.sv - directed bench for one-byte and two-byte frame serializers
module tb_crc_frame_serializer;
    logic CLK;
    logic RST;

    crc_frame_serializer_if in1 ();
    crc_frame_serializer_if in2 ();

    crc_frame_serializer #(.DATA_LENGTH(1), .DRAIN_CYCLES(9)) u_dut1 (
        .CLK (CLK),
        .RST (RST),
        .bus (in1)
    );

    crc_frame_serializer #(.DATA_LENGTH(2), .DRAIN_CYCLES(9)) u_dut2 (
        .CLK (CLK),
        .RST (RST),
        .bus (in2)
    );

    int n_assert = 0;
    int n_fail   = 0;
    logic s_rdy, s_act, s_sd, s_busy, s_fd;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample(input int sel);
        if (sel == 1) begin
            s_rdy = in1.In_Ready; s_act = in1.Active; s_sd = in1.Ser_Data;
            s_busy = in1.Busy; s_fd = in1.Frame_Done;
        end else begin
            s_rdy = in2.In_Ready; s_act = in2.Active; s_sd = in2.Ser_Data;
            s_busy = in2.Busy; s_fd = in2.Frame_Done;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input int sel, input string tag);
        sample(sel);
        check({tag, " rdy"},  16'(s_rdy),  16'd1);
        check({tag, " act"},  16'(s_act),  16'd0);
        check({tag, " sd"},   16'(s_sd),   16'd0);
        check({tag, " busy"}, 16'(s_busy), 16'd0);
        check({tag, " fd"},   16'(s_fd),   16'd0);
    endtask

    task automatic check_drain(input int sel);
        for (int d = 0; d < 9; d++) begin
            sample(sel);
            check($sformatf("u%0d drain%0d act", sel, d),  16'(s_act),  16'd0);
            check($sformatf("u%0d drain%0d sd", sel, d),   16'(s_sd),   16'd0);
            check($sformatf("u%0d drain%0d rdy", sel, d),  16'(s_rdy),  16'd0);
            check($sformatf("u%0d drain%0d busy", sel, d), 16'(s_busy), 16'd1);
            check($sformatf("u%0d drain%0d fd", sel, d),   16'(s_fd),   (d == 8) ? 16'd1 : 16'd0);
            tick();
        end
        check_idle(sel, $sformatf("u%0d after drain", sel));
    endtask

    // Entered just after the edge that accepted the last byte of the frame.
    task automatic check_frame(input int sel, input int nbits, input logic [15:0] bits);
        for (int j = 0; j < nbits; j++) begin
            sample(sel);
            check($sformatf("u%0d bit%0d act", sel, j), 16'(s_act), 16'd1);
            check($sformatf("u%0d bit%0d sd", sel, j),  16'(s_sd),  16'(bits[j]));
            check($sformatf("u%0d bit%0d busy", sel, j), 16'(s_busy), 16'd1);
            tick();
        end
        check_drain(sel);
    endtask

    initial begin
        RST = 1'b1;
        in1.In_Data = 8'h00; in1.In_Valid = 1'b0; in1.Flush = 1'b0;
        in2.In_Data = 8'h00; in2.In_Valid = 1'b0; in2.Flush = 1'b0;
        tick();
        tick();
        check_idle(1, "reset u1");
        check_idle(2, "reset u2");
        RST = 1'b0;
        tick();
        check_idle(1, "post reset u1");

        // One byte 0xA5: serial order 1,0,1,0,0,1,0,1
        in1.In_Data = 8'hA5; in1.In_Valid = 1'b1;
        tick();
        in1.In_Valid = 1'b0;
        check_frame(1, 8, 16'b0000_0000_1010_0101);

        // Two bytes 0x01, 0x80 with gaps on In_Valid
        in2.In_Data = 8'h01; in2.In_Valid = 1'b1;
        tick();
        in2.In_Valid = 1'b0;
        tick();
        sample(2);
        check("u2 gap act", 16'(s_act), 16'd0);
        check("u2 gap rdy", 16'(s_rdy), 16'd1);
        tick();
        in2.In_Data = 8'h80; in2.In_Valid = 1'b1;
        tick();
        in2.In_Valid = 1'b0;
        check_frame(2, 16, 16'b1000_0000_0000_0001);

        // Back-to-back with In_Valid held: 0x3C then 0xC3
        in1.In_Data = 8'h3C; in1.In_Valid = 1'b1;
        tick();
        in1.In_Data = 8'hC3;
        check_frame(1, 8, 16'b0000_0000_0011_1100);
        tick();
        in1.In_Valid = 1'b0;
        check_frame(1, 8, 16'b0000_0000_1100_0011);

        // Flush while bit 3 of 0x5A is on the line
        in1.In_Data = 8'h5A; in1.In_Valid = 1'b1;
        tick();
        in1.In_Valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            sample(1);
            check($sformatf("flush bit%0d act", j), 16'(s_act), 16'd1);
            check($sformatf("flush bit%0d sd", j),  16'(s_sd),  16'(j == 1 || j == 3));
            if (j == 3) in1.Flush = 1'b1;
            tick();
        end
        in1.Flush = 1'b0;
        check_drain(1);
        in1.In_Data = 8'hFF; in1.In_Valid = 1'b1;
        tick();
        in1.In_Valid = 1'b0;
        check_frame(1, 8, 16'h00FF);

        // Flush in LOAD after one byte, with a concurrent byte that must vanish
        in2.In_Data = 8'h11; in2.In_Valid = 1'b1;
        tick();
        in2.In_Data = 8'h22; in2.Flush = 1'b1;
        tick();
        in2.Flush = 1'b0;
        sample(2);
        check("load flush act", 16'(s_act), 16'd0);
        check("load flush rdy", 16'(s_rdy), 16'd1);
        in2.In_Data = 8'h33;
        tick();
        sample(2);
        check("load flush one byte act", 16'(s_act), 16'd0);
        in2.In_Data = 8'h44;
        tick();
        in2.In_Valid = 1'b0;
        check_frame(2, 16, 16'b0100_0100_0011_0011);

        // Asynchronous reset in the middle of a burst
        in1.In_Data = 8'h0F; in1.In_Valid = 1'b1;
        tick();
        in1.In_Valid = 1'b0;
        tick();
        sample(1);
        check("pre async act", 16'(s_act), 16'd1);
        #2;
        RST = 1'b1;
        #1;
        check_idle(1, "async reset");
        tick();
        RST = 1'b0;
        check_idle(1, "async release");
        in1.In_Data = 8'h81; in1.In_Valid = 1'b1;
        tick();
        in1.In_Valid = 1'b0;
        check_frame(1, 8, 16'b0000_0000_1000_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/crc_frame_serializer.md
# crc_frame_serializer

Upstream feeder for the serial CRC-8 engine. Collects a frame of DATA_LENGTH bytes over a valid/ready byte interface, then drives the engine's serial `Data`/`Active` inputs with one contiguous burst of DATA_LENGTH*8 bits, LSB of byte 0 first. It then holds `Active` low long enough for the engine to shift out its 8-bit CRC and re-initialise before the next frame. `Active` is never interrupted mid-frame, so the engine's bit counter stays consistent.

## Interface
- DATA_LENGTH, 1: bytes per frame, ≥1.
- DRAIN_CYCLES, 9: `Active`-low cycles after each burst. 8 CRC output cycles plus 1 engine re-init cycle; values <9 are illegal.
- CLK  in  1  single clock, all logic on posedge.
- RST  in  1  asynchronous, active-high reset.
- In_Data  in  8  byte to load.
- In_Valid  in  1  In_Data valid.
- In_Ready  out  1  block accepts a byte this cycle; transfer = In_Valid & In_Ready at posedge.
- Flush  in  1  synchronous abort of the current frame.
- Ser_Data  out  1  serial bit to CRC `Data`.
- Active  out  1  to CRC `Active`; high exactly while frame bits are presented.
- Busy  out  1  high in SHIFT or DRAIN.
- Frame_Done  out  1  one-cycle pulse on the last DRAIN cycle.

## Operation
- Frame buffer: DATA_LENGTH*8 bits. Byte count width is $clog2(DATA_LENGTH+1). Bit count width is $clog2(DATA_LENGTH*8). Drain count width is $clog2(DRAIN_CYCLES+1).
- States:
  - LOAD: In_Ready=1. Each transfer writes In_Data into buffer slot byte_cnt and increments byte_cnt. The transfer at byte_cnt==DATA_LENGTH-1 moves the block to SHIFT and clears bit_cnt.
  - SHIFT: Active=1, Ser_Data=buffer[bit_cnt], with bit index = byte*8+bit. bit_cnt increments every cycle. At bit_cnt==DATA_LENGTH*8-1 the block moves to DRAIN and clears drain_cnt.
  - DRAIN: Active=0, Ser_Data=0, In_Ready=0. drain_cnt increments every cycle. At drain_cnt==DRAIN_CYCLES-1, Frame_Done=1 and the block moves to LOAD with byte_cnt=0.
- Active, Ser_Data, In_Ready, Busy and Frame_Done decode from registered state/counters only. No input-to-output combinational path.
- Flush, sampled at posedge:
  - LOAD: byte_cnt←0, partial bytes discarded. A concurrent In_Valid transfer is ignored.
  - SHIFT: go to DRAIN immediately, so the engine flushes its partial CRC and re-initialises. Frame_Done still pulses at the end of DRAIN.
  - DRAIN: no effect.
- Buffer contents are not cleared between frames. Only slots written in the current frame are shifted.

## Timing
- Reset (RST high, asynchronous): state=LOAD, all counters 0.
  - Outputs during and after reset: In_Ready=1, Active=0, Ser_Data=0, Busy=0, Frame_Done=0.
  - First transfer is possible on the first posedge after RST falls.
- Reset mid-SHIFT: Active drops asynchronously. The downstream CRC engine is reset by the system at the same time.
- Latency: last-byte transfer at edge k → Active=1 with bit 0 on Ser_Data from edge k, through edge k+DATA_LENGTH*8.
  - The CRC samples bit j at edge k+1+j.
  - Active=0 from edge k+DATA_LENGTH*8.
  - Frame_Done high during cycle k+DATA_LENGTH*8+DRAIN_CYCLES-1.
  - In_Ready=1 again from edge k+DATA_LENGTH*8+DRAIN_CYCLES.
- Frame period with back-to-back input: DATA_LENGTH + DATA_LENGTH*8 + DRAIN_CYCLES cycles.
- In_Valid may stay high across frames. Bytes held during SHIFT/DRAIN (In_Ready=0) are neither lost nor duplicated.

## Test plan
- Reset: assert RST mid-cycle → all outputs at reset values immediately. In_Ready=1 on the first cycle after release.
- DATA_LENGTH=1, byte 0xA5 → Ser_Data sequence 1,0,1,0,0,1,0,1 with Active high for exactly 8 cycles. Then 9 low cycles, Frame_Done pulse on the 9th. CRC engine output matches the golden model.
- DATA_LENGTH=2, bytes 0x01, 0x80 with In_Valid gaps → Active contiguous for 16 cycles. Bit 0 = 1, bit 15 = 1, all others 0.
- Back-to-back frames, In_Valid held high (DATA_LENGTH=1, 0x3C then 0xC3) → second byte accepted only after Frame_Done. Active gap = 9 cycles. Both CRCs are correct with no re-init corruption.
- Flush at SHIFT bit 3 → Active low next cycle, 9-cycle DRAIN, Frame_Done pulse. The next frame (0xFF) produces the correct CRC.
- Flush in LOAD after 1 of 2 bytes, with concurrent In_Valid → byte_cnt=0. The next two bytes form the frame and the concurrent byte is absent from the output.
